// File: rtl/serial_pair_serializer.sv
// serial_pair_serializer
//
// Parallel-to-serial transmitter for operand pairs. A pair (in_a, in_b) is
// taken over a valid/ready handshake and streamed out one bit per cycle on
// a/b, preceded by a one-cycle cmp_rst strobe that clears the downstream
// serial comparator so its history starts fresh on the first bit.
//
// Bit order: MSB first by default. Defining SERIAL_PAIR_LSB_FIRST_EN switches
// to LSB first (shift right). Framing, handshake and timing are unchanged.
//
// Handshake: a pair is accepted on a rising edge where in_valid & in_ready.
// in_ready depends only on registered state (high in IDLE and on the last
// SHIFT cycle); the source must hold its pair stable until accepted.
// There is no backpressure on the serial side.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   source presents an operand pair
//   in_ready   out  pair can be accepted this cycle
//   in_a/in_b  in   W-bit operands
//   ser_valid  out  a/b carry a valid bit this cycle
//   a/b        out  serial operand bits (0 when ser_valid=0)
//   ser_last   out  current bit is the final bit of the word
//   cmp_rst    out  comparator reset strobe (CLEAR state, or block in reset)
//   busy       out  state is not IDLE
module serial_pair_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         ser_valid,
  output logic         a,
  output logic         b,
  output logic         ser_last,
  output logic         cmp_rst,
  output logic         busy
);

  localparam int                CNT_W    = $clog2(W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       sh_a_q, sh_a_d;
  logic [W-1:0]       sh_b_q, sh_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               last_bit;
  logic               accept;

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  // The last SHIFT cycle also accepts, which gives back-to-back words with
  // only the CLEAR cycle between them.
  assign in_ready = (state_q == ST_IDLE) || last_bit;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
`ifdef SERIAL_PAIR_LSB_FIRST_EN
        sh_a_d = {1'b0, sh_a_q[W-1:1]};
        sh_b_d = {1'b0, sh_b_q[W-1:1]};
`else
        sh_a_d = {sh_a_q[W-2:0], 1'b0};
        sh_b_d = {sh_b_q[W-2:0], 1'b0};
`endif
        if (last_bit) begin
          cnt_d   = '0;
          state_d = accept ? ST_CLEAR : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new pair overrides the shift of the final bit.
    if (accept) begin
      sh_a_d = in_a;
      sh_b_d = in_b;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_valid = (state_q == ST_SHIFT);
`ifdef SERIAL_PAIR_LSB_FIRST_EN
  assign a = ser_valid & sh_a_q[0];
  assign b = ser_valid & sh_b_q[0];
`else
  assign a = ser_valid & sh_a_q[W-1];
  assign b = ser_valid & sh_b_q[W-1];
`endif
  assign ser_last = last_bit;
  assign busy     = (state_q != ST_IDLE);
  // Combinational with rst_n so the comparator is held cleared while this
  // block is in reset.
  assign cmp_rst  = (state_q == ST_CLEAR) | ~rst_n;

endmodule

// File: tb/tb_serial_pair_serializer.sv
module tb_serial_pair_serializer;

  localparam int REL_NONE = 0;
  localparam int REL_GT   = 1;
  localparam int REL_EQ   = 2;
  localparam int REL_LT   = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       ser_valid;
  logic       a;
  logic       b;
  logic       ser_last;
  logic       cmp_rst;
  logic       busy;

  always #5 clk = ~clk;

  serial_pair_serializer #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .ser_valid (ser_valid),
    .a         (a),
    .b         (b),
    .ser_last  (ser_last),
    .cmp_rst   (cmp_rst),
    .busy      (busy)
  );

  // ---------------- vector table ----------------
  // One row per cycle: inputs driven during the cycle and the outputs
  // expected in that same cycle. rel is the expected comparator verdict on
  // the ser_last cycle (REL_NONE elsewhere).
  typedef struct {
    logic       v;
    logic [7:0] ia;
    logic [7:0] ib;
    logic       rdy;
    logic       sv;
    logic       ea;
    logic       eb;
    logic       el;
    logic       cr;
    logic       bz;
    int         rel;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  function automatic void row(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                              input logic rdy, input logic sv, input logic ea, input logic eb,
                              input logic el, input logic cr, input logic bz, input int rel);
    vec_t r;
    r.v = v; r.ia = ia; r.ib = ib; r.rdy = rdy; r.sv = sv; r.ea = ea; r.eb = eb;
    r.el = el; r.cr = cr; r.bz = bz; r.rel = rel;
    vq.push_back(r);
  endfunction

  // Bit i of the serial stream (i = 0 is the first bit on the wire).
  function automatic logic bit_at(input logic [7:0] w, input int i);
`ifdef SERIAL_PAIR_LSB_FIRST_EN
    return w[i];
`else
    return w[7 - i];
`endif
  endfunction

  // IDLE cycle: ready, nothing on the serial side.
  function automatic void idle_row(input logic v, input logic [7:0] ia, input logic [7:0] ib);
    row(v, ia, ib, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, REL_NONE);
  endfunction

  // CLEAR cycle plus eight SHIFT cycles for word pair wa/wb. During the
  // non-last cycles the source drives hold_v/ha/hb; on the last bit it drives
  // last_v with the same data.
  function automatic void stream(input logic [7:0] wa, input logic [7:0] wb,
                                 input logic hold_v, input logic [7:0] ha, input logic [7:0] hb,
                                 input logic last_v, input int rel);
    row(hold_v, ha, hb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, REL_NONE);
    for (int i = 0; i < 8; i++) begin
      row((i == 7) ? last_v : hold_v, ha, hb, (i == 7), 1'b1,
          bit_at(wa, i), bit_at(wb, i), (i == 7), 1'b0, 1'b1,
          (i == 7) ? rel : REL_NONE);
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int k, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d] %s: got %0d expected %0d", tag, k, nm, act, exp);
  endtask

  // Applies the table cycle by cycle. A reference serial comparator runs
  // alongside on the DUT's serial outputs and its verdict is checked against
  // the hand-computed relation on each ser_last cycle.
  task automatic run_table(input string tag);
    logic m_gt, m_lt, c_gt, c_lt;
    int   rel_act;
    m_gt = 1'b0;
    m_lt = 1'b0;
    for (int k = 0; k < vq.size(); k++) begin
      in_valid = vq[k].v;
      in_a     = vq[k].ia;
      in_b     = vq[k].ib;
      #1;
      chk(tag, k, "in_ready",  {31'd0, in_ready},  {31'd0, vq[k].rdy});
      chk(tag, k, "ser_valid", {31'd0, ser_valid}, {31'd0, vq[k].sv});
      chk(tag, k, "a",         {31'd0, a},         {31'd0, vq[k].ea});
      chk(tag, k, "b",         {31'd0, b},         {31'd0, vq[k].eb});
      chk(tag, k, "ser_last",  {31'd0, ser_last},  {31'd0, vq[k].el});
      chk(tag, k, "cmp_rst",   {31'd0, cmp_rst},   {31'd0, vq[k].cr});
      chk(tag, k, "busy",      {31'd0, busy},      {31'd0, vq[k].bz});
      if (cmp_rst) begin
        m_gt = 1'b0;
        m_lt = 1'b0;
      end else if (ser_valid) begin
`ifdef SERIAL_PAIR_LSB_FIRST_EN
        // LSB first: a later differing bit overrides earlier ones.
        c_gt = (a != b) ? (a & ~b) : m_gt;
        c_lt = (a != b) ? (~a & b) : m_lt;
`else
        // MSB first: the first differing bit decides.
        c_gt = (m_gt | m_lt) ? m_gt : (a & ~b);
        c_lt = (m_gt | m_lt) ? m_lt : (~a & b);
`endif
        if (vq[k].rel != REL_NONE) begin
          rel_act = c_gt ? REL_GT : (c_lt ? REL_LT : REL_EQ);
          chk(tag, k, "cmp_rel", rel_act, vq[k].rel);
        end
        m_gt = c_gt;
        m_lt = c_lt;
      end
      @(posedge clk);
      #1;
    end
    vq.delete();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, 0, "in_ready",  {31'd0, in_ready},  32'd1);
    chk(tag, 0, "ser_valid", {31'd0, ser_valid}, 32'd0);
    chk(tag, 0, "a",         {31'd0, a},         32'd0);
    chk(tag, 0, "b",         {31'd0, b},         32'd0);
    chk(tag, 0, "ser_last",  {31'd0, ser_last},  32'd0);
    chk(tag, 0, "busy",      {31'd0, busy},      32'd0);
    chk(tag, 0, "cmp_rst",   {31'd0, cmp_rst},   32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = 8'h00;
    in_b     = 8'h00;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pair A5/5A with a competing pair offered during the stream.
    idle_row(1'b1, 8'hA5, 8'h5A);
    stream(8'hA5, 8'h5A, 1'b1, 8'h33, 8'hCC, 1'b0, REL_GT);
    idle_row(1'b0, 8'h00, 8'h00);
    run_table("single_stall");

    // Back-to-back: second pair accepted on the last bit of the first.
    idle_row(1'b1, 8'h10, 8'h10);
    stream(8'h10, 8'h10, 1'b1, 8'h03, 8'h04, 1'b1, REL_EQ);
    stream(8'h03, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0, REL_LT);
    idle_row(1'b0, 8'h00, 8'h00);
    run_table("b2b");

    // Bit-order sensitive pair.
    idle_row(1'b1, 8'h01, 8'h80);
    stream(8'h01, 8'h80, 1'b0, 8'h00, 8'h00, 1'b0, REL_LT);
    idle_row(1'b0, 8'h00, 8'h00);
    run_table("order");

    // Reset in the middle of a word (bit index 3, cycle 5 after acceptance).
    in_valid = 1'b1;
    in_a     = 8'h77;
    in_b     = 8'h11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("midreset", 3, "ser_valid", {31'd0, ser_valid}, 32'd1);
    chk("midreset", 3, "a", {31'd0, a}, {31'd0, bit_at(8'h77, 3)});
    chk("midreset", 3, "b", {31'd0, b}, {31'd0, bit_at(8'h11, 3)});
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset", 0, "busy",      {31'd0, busy},      32'd0);
    chk("post_reset", 0, "cmp_rst",   {31'd0, cmp_rst},   32'd0);
    chk("post_reset", 0, "ser_valid", {31'd0, ser_valid}, 32'd0);

    idle_row(1'b1, 8'hFF, 8'h00);
    stream(8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, REL_GT);
    idle_row(1'b0, 8'h00, 8'h00);
    run_table("after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_pair_serializer.md
# serial_pair_serializer

Parallel-to-serial transmitter for operand pairs. Accepts two W-bit words over a valid/ready handshake and streams them out one bit per cycle on `a`/`b`, MSB first, framed so that the team's serial comparators can consume them directly. Before every word it drives a one-cycle `cmp_rst` pulse, so the downstream comparator's synchronous history reset lines up with the first bit. It sits between a parallel operand source and a serial comparator.

## Interface

- `W`, default 8: operand width in bits; legal range W ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  source presents an operand pair.
- `in_ready`  out  1  block can accept a pair this cycle.
- `in_a`  in  W  operand A.
- `in_b`  in  W  operand B.
- `ser_valid`  out  1  `a`/`b` carry a valid bit this cycle.
- `a`  out  1  serial bit of operand A.
- `b`  out  1  serial bit of operand B.
- `ser_last`  out  1  current bit is the final bit of the word.
- `cmp_rst`  out  1  synchronous reset strobe for the downstream comparator.
- `busy`  out  1  state is not IDLE.

## Operation

- FSM states: IDLE, CLEAR, SHIFT.
- Acceptance occurs on a rising edge with `in_valid & in_ready`. `in_a`/`in_b` are captured into shift registers `sh_a`/`sh_b`. Bit counter `cnt` ($clog2(W) bits) is set to 0.
- IDLE: `in_ready`=1. On acceptance → CLEAR.
- CLEAR: exactly one cycle. `cmp_rst`=1, `ser_valid`=0, `in_ready`=0 → SHIFT.
- SHIFT: `ser_valid`=1, `a`=`sh_a[W-1]`, `b`=`sh_b[W-1]`. Each edge shifts `sh_a`/`sh_b` left by one and increments `cnt`. `ser_last`=1 when `cnt`==W-1.
- Last SHIFT cycle (`cnt`==W-1): `in_ready`=1. With acceptance → CLEAR (back-to-back). Without acceptance → IDLE.
- Non-last SHIFT cycles: `in_ready`=0. `in_valid` is ignored, and the source must hold its data.
- When `ser_valid`=0: `a`=0, `b`=0, `ser_last`=0.
- `cmp_rst` = (state==CLEAR) | ~`rst_n`. This is combinational, so the comparator is also held cleared during block reset.
- `busy` = (state != IDLE).
- No backpressure from the serial side. Bits are emitted unconditionally once SHIFT starts.

## Timing

- Reset values (asynchronous, while `rst_n`=0): state IDLE, `in_ready`=1, `ser_valid`=0, `a`=0, `b`=0, `ser_last`=0, `busy`=0, `cmp_rst`=1, `cnt`=0, shift registers 0.
- Acceptance at edge k:
  - `cmp_rst` high in cycle k+1.
  - First bit in cycle k+2.
  - Last bit in cycle k+W+1.
- Throughput: one pair per W+1 cycles when back-to-back. The CLEAR cycle is the only gap.
- Downstream comparator result for a word is valid in the `ser_last` cycle.
- Reset mid-operation: all outputs drop to reset values immediately, and the partial word is discarded. After release, the block restarts in IDLE with no residual bits.
- All outputs except `cmp_rst` are decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration

- `SERIAL_PAIR_LSB_FIRST_EN`
  - Defined: shift right; `a`=`sh_a[0]`, `b`=`sh_b[0]`. This order is for LSB-first comparators.
  - Undefined (default): MSB first as described above.
- Framing, handshake and timing are identical in both modes.

## Test plan

- Reset: hold `rst_n`=0 mid-stream → `in_ready`=1, `ser_valid`=0, `a`=`b`=0, `ser_last`=0, `busy`=0, `cmp_rst`=1.
- Single pair, W=8, A=0xA5, B=0x5A, accepted at edge 0:
  - `cmp_rst`=1 in cycle 1.
  - Cycles 2–9: `a`=1,0,1,0,0,1,0,1 and `b`=0,1,0,1,1,0,1,0.
  - `ser_last` only in cycle 9.
  - Attached MSB-first comparator shows `a_greater_b`=1 at cycle 9.
- Back-to-back: pairs (0x10,0x10) then (0x03,0x04) with `in_valid` held:
  - Second pair accepted at the cycle-9 edge, CLEAR in cycle 10, bits in cycles 11–18.
  - Comparator shows `a_eq_b`=1 at cycle 9 and `a_less_b`=1 at cycle 18.
- Stall: assert `in_valid` with a new pair during SHIFT cycles 2–8 → `in_ready`=0, nothing accepted, current stream undisturbed.
- Reset mid-word: drop `rst_n` during bit 3 → outputs zero, `cmp_rst`=1 immediately. After release, a new pair 0xFF/0x00 streams cleanly starting 2 cycles after acceptance.
- With `SERIAL_PAIR_LSB_FIRST_EN`, A=0x01, B=0x80 → first bit `a`=1, `b`=0; last bit `a`=0, `b`=1.
